// File: rtl/serial_pkg.sv
// Shared types and constants for the serial controller transmit path.
package serial_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

    typedef logic src_t;

    localparam src_t SRC_ECHO = 1'b0;
    localparam src_t SRC_HOST = 1'b1;

    // Round-robin partner of a source.
    function automatic src_t other_src(input src_t s);
        return ~s;
    endfunction

endpackage

// File: rtl/serial_byte_fifo.sv
// Small byte FIFO with first-word-fall-through read data. A push into a full
// FIFO succeeds only when a pop happens in the same cycle.
module serial_byte_fifo
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    CLK_100_I,
    input  logic                    RST_I,
    input  logic                    push,
    input  logic [BYTE_W-1:0]       push_data,
    input  logic                    pop,
    output logic [BYTE_W-1:0]       rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK_100_I) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop balance.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_sched.sv
// Transmit scheduler: buffers echo bytes, arbitrates echo/host round-robin,
// gates launches on peer flow control and runs the transmitter handshake.
module serial_tx_sched
    import serial_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic              CLK_100_I,
    input  logic              RST_I,
    input  logic [BYTE_W-1:0] ECHO_BYTE_I,
    input  logic              ECHO_STB_I,
    input  logic [BYTE_W-1:0] HOST_BYTE_I,
    input  logic              HOST_VALID_I,
    output logic              HOST_READY_O,
    input  logic              FLOW_OK_I,
    input  logic              TX_BUSY_I,
    output logic [BYTE_W-1:0] TX_BYTE_O,
    output logic              TX_STB_O,
    output logic              OVF_O,
    output logic              TO_ERR_O
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    tx_state_t   state_q;
    tx_state_t   state_d;
    src_t        prio_q;
    logic [TW-1:0] timer_q;

    logic        grant_echo;
    logic        grant_host;
    logic        launch;
    logic        ack_expired;
    logic        echo_drop;

    logic [BYTE_W-1:0]              fifo_rd_data;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;

    serial_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_echo_fifo (
        .CLK_100_I (CLK_100_I),
        .RST_I     (RST_I),
        .push      (ECHO_STB_I),
        .push_data (ECHO_BYTE_I),
        .pop       (grant_echo),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign launch       = grant_echo | grant_host;
    // Echo byte is lost only when the FIFO is full and not draining this cycle.
    assign echo_drop    = ECHO_STB_I & fifo_full & ~grant_echo;
    assign HOST_READY_O = grant_host & ~RST_I;

    // Occupancy and empty flag must always agree.
    always_comb begin
        assert (fifo_empty == (fifo_count == '0));
    end

    // Next-state, arbitration and handshake decode.
    always_comb begin
        state_d     = state_q;
        grant_echo  = 1'b0;
        grant_host  = 1'b0;
        ack_expired = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (FLOW_OK_I && !TX_BUSY_I) begin
                    if (!fifo_empty && (!HOST_VALID_I || prio_q == SRC_ECHO)) begin
                        grant_echo = 1'b1;
                    end else if (HOST_VALID_I) begin
                        grant_host = 1'b1;
                    end
                end
                if (grant_echo || grant_host) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (TX_BUSY_I) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = IDLE;
                    ack_expired = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY_I) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Launch strobe, byte latch and round-robin pointer update on each grant.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            TX_STB_O  <= 1'b0;
            TX_BYTE_O <= '0;
            prio_q    <= SRC_ECHO;
        end else begin
            TX_STB_O <= launch;
            if (grant_echo) begin
                TX_BYTE_O <= fifo_rd_data;
                prio_q    <= other_src(SRC_ECHO);
            end else if (grant_host) begin
                TX_BYTE_O <= HOST_BYTE_I;
                prio_q    <= other_src(SRC_HOST);
            end
        end
    end

    // Acknowledge timer: cleared on launch, saturating count while waiting.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            timer_q <= '0;
        end else if (launch) begin
            timer_q <= '0;
        end else if (state_q == WAIT_ACK && timer_q != '1) begin
            timer_q <= timer_q + TIMER_ONE;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            OVF_O    <= 1'b0;
            TO_ERR_O <= 1'b0;
        end else begin
            if (echo_drop) begin
                OVF_O <= 1'b1;
            end
            if (ack_expired) begin
                TO_ERR_O <= 1'b1;
            end
        end
    end

endmodule
